// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, with sign fix-up applied as the result is written to hi/lo.
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold the last completed result
// CALC   | WIDTH iteration cycles, counter runs down to zero
// DONE   | one-cycle done pulse; hi/lo already carry the new result
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_state == S_CALC) && (r_cnt == '0);
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Multiply step: acc_lo holds the multiplier and shifts out as the product shifts in.
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;

  assign w_sum    = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

  // Restoring divide step: acc_hi is the partial remainder, acc_lo the dividend/quotient.
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;

  assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_mcand};
  assign w_div_hi = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_lo = {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};

  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo = r_is_div ? w_div_lo : w_mul_lo;
  assign w_prod    = {w_mul_hi, w_mul_lo};
  assign w_prod_s  = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_s[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -w_div_hi : w_div_hi;
        w_res_lo = r_neg_q ? -w_div_lo : w_div_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nxt = S_CALC;
        S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a      <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_cnt    <= CW'(WIDTH - 1);
      r_is_div <= op[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_div0   <= op[1] && (b == '0);
      r_a      <= a;
      r_mcand  <= w_b_mag;
      r_acc_hi <= '0;
      r_acc_lo <= w_a_mag;
    end else if ((r_state == S_CALC) && !flush) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      // Final iteration: result lands on hi/lo on the same edge that enters DONE.
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH = 32): latency, signed/unsigned results,
// divide-by-zero, overflow corner, flush, ignored restart and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op in the current cycle T; expects done exactly at T+33 and leaves
  // the bench in cycle T+34 (IDLE). restart != 0 re-asserts start with other
  // operands in cycle T+restart, which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] ehi,
                        input logic [31:0] elo, input int restart);
    int lat;
    lat = -1;
    op = o; a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
    chk1({tag, " busy@T+1"}, busy, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (n == restart) begin
        start = 1'b1; op = ~o; a = 32'h1234_5678; b = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk32({tag, " done cycle"}, 32'(lat), 32'd33);
    chk1({tag, " busy@done"}, busy, 1'b1);
    chk32({tag, " hi"}, hi, ehi);
    chk32({tag, " lo"}, lo, elo);
    tick();
    chk1({tag, " busy@T+34"}, busy, 1'b0);
    chk1({tag, " done@T+34"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    tick();
    tick();
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk32("reset hi", hi, 32'h0);
    chk32("reset lo", lo, 32'h0);
    rst = 1'b0;
    tick();

    run_op("mult -1*2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu 100/7 restart", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);
    run_op("divu by 0", OP_DIVU, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
    run_op("div by 0", OP_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult minneg^2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div minneg/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);

    // Flush at T+10: no done, hi/lo keep the minneg/-1 result.
    op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      chk1("flush no early done", done, 1'b0);
      tick();
    end
    chk1("flush busy@T+10", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flush busy@T+11", busy, 1'b0);
    chk1("flush done@T+11", done, 1'b0);
    chk32("flush hi kept", hi, 32'h0000_0000);
    chk32("flush lo kept", lo, 32'h8000_0000);
    run_op("after flush", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0);

    // start and flush together while IDLE: not accepted.
    op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk1("start+flush busy", busy, 1'b0);
    tick();
    chk1("start+flush busy later", busy, 1'b0);
    chk1("start+flush done", done, 1'b0);

    // Reset at T+20 abandons the operation.
    op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk1("rst busy@T+20", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rst busy@T+21", busy, 1'b0);
    chk1("rst done@T+21", done, 1'b0);
    chk32("rst hi@T+21", hi, 32'h0);
    chk32("rst lo@T+21", lo, 32'h0);
    for (int n = 21; n <= 34; n++) begin
      chk1("rst no done", done, 1'b0);
      tick();
    end

    run_op("divu after rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
